// File: rtl/booth_pkg.sv
// Shared types and width-derived helpers for the sequential radix-2 Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PASS = 2'd0,
    ADD  = 2'd1,
    SUB  = 2'd2
  } booth_op_e;

  localparam int DEFAULT_WIDTH = 8;

  // One extra iteration covers the extension bit that makes unsigned operands exact.
  function automatic int n_iter(input int width);
    return width + 1;
  endfunction

  function automatic int count_bits(input int width);
    return $clog2(width + 2);
  endfunction

  function automatic booth_op_e booth_decode(input logic q0, input logic q_m1);
    case ({q0, q_m1})
      2'b01:   return ADD;
      2'b10:   return SUB;
      default: return PASS;
    endcase
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational Booth step: conditional add/sub of the multiplicand, then arithmetic shift right.
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] qx,
  input  logic           q_m1,
  input  logic [WIDTH:0] mx,
  output logic [WIDTH:0] a_next,
  output logic [WIDTH:0] qx_next,
  output logic           q_m1_next
);

  logic [WIDTH:0] sum;
  booth_op_e      op;

  always_comb begin
    op  = booth_decode(qx[0], q_m1);
    sum = a;
    case (op)
      ADD:     sum = a + mx;
      SUB:     sum = a - mx;
      default: sum = a;
    endcase
  end

  // {sum, qx, q_m1} shifted right by one with the sign of sum replicated.
  always_comb begin
    a_next    = {sum[WIDTH], sum[WIDTH:1]};
    qx_next   = {sum[0], qx[WIDTH:1]};
    q_m1_next = qx[0];
  end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: one step per clock, start/done handshake, held product.
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               tc,
  input  logic [WIDTH-1:0]   M,
  input  logic [WIDTH-1:0]   Q,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] Z
);

  localparam int N_ITER = n_iter(WIDTH);
  localparam int CW     = count_bits(WIDTH);

  state_e          state, state_next;
  logic [CW-1:0]   count;
  logic [WIDTH:0]  a, qx, mx;
  logic            q_m1;
  logic [WIDTH:0]  a_next, qx_next;
  logic            q_m1_next;
  logic            accept;
  logic            last_step;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a         (a),
    .qx        (qx),
    .q_m1      (q_m1),
    .mx        (mx),
    .a_next    (a_next),
    .qx_next   (qx_next),
    .q_m1_next (q_m1_next)
  );

  assign accept    = start && (state == IDLE || state == DONE);
  assign last_step = (state == RUN) && (count == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      a     <= '0;
      qx    <= '0;
      q_m1  <= 1'b0;
      mx    <= '0;
      Z     <= '0;
    end else if (accept) begin
      count <= CW'(N_ITER);
      a     <= '0;
      qx    <= tc ? {Q[WIDTH-1], Q} : {1'b0, Q};
      q_m1  <= 1'b0;
      mx    <= tc ? {M[WIDTH-1], M} : {1'b0, M};
    end else if (state == RUN) begin
      count <= count - CW'(1);
      a     <= a_next;
      qx    <= qx_next;
      q_m1  <= q_m1_next;
      // The full product fits in 2*WIDTH bits, so the top two bits of {A,Qx} are pure sign.
      if (last_step) Z <= {a_next[WIDTH-2:0], qx_next};
    end
  end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult: directed 8-bit vectors, handshake corners, 16-bit random sweep.
module tb_booth_seq_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start8, tc8, busy8, done8;
  logic [7:0]  m8, q8;
  logic [15:0] z8;

  logic        start16, tc16, busy16, done16;
  logic [15:0] m16, q16;
  logic [31:0] z16;

  int total = 0;
  int bad   = 0;

  booth_seq_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .tc(tc8), .M(m8), .Q(q8),
    .busy(busy8), .done(done8), .Z(z8)
  );

  booth_seq_mult #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .tc(tc16), .M(m16), .Q(q16),
    .busy(busy16), .done(done16), .Z(z16)
  );

  typedef struct {
    logic        tc;
    logic [7:0]  m;
    logic [7:0]  q;
    logic [15:0] z;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait8(output int lat, output int busy_cnt, output bit overlap);
    lat = 0; busy_cnt = 0; overlap = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy8 && done8) overlap = 1'b1;
      if (busy8) busy_cnt++;
      if (done8) begin lat = k; break; end
    end
  endtask

  task automatic start_8(input logic tc, input logic [7:0] m, input logic [7:0] q);
    @(negedge clk);
    tc8 = tc; m8 = m; q8 = q; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
  endtask

  task automatic mult8(input string name, input logic tc, input logic [7:0] m,
                       input logic [7:0] q, input logic [15:0] z_exp);
    int lat, bc;
    bit ov;
    start_8(tc, m, q);
    wait8(lat, bc, ov);
    check({name, " z"}, 64'(z8), 64'(z_exp));
    check({name, " latency"}, 64'(lat), 64'd10);
    check({name, " busy cycles"}, 64'(bc), 64'd9);
    check({name, " busy&done"}, 64'(ov), 64'd0);
  endtask

  task automatic mult16(input string name, input logic tc, input logic [15:0] m,
                        input logic [15:0] q, input logic [31:0] z_exp);
    int lat;
    @(negedge clk);
    tc16 = tc; m16 = m; q16 = q; start16 = 1'b1;
    @(posedge clk);
    #1 start16 = 1'b0;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done16) begin lat = k; break; end
    end
    check({name, " z"}, 64'(z16), 64'(z_exp));
    check({name, " latency"}, 64'(lat), 64'd18);
  endtask

  initial begin
    int lat, bc;
    bit ov, seen;
    logic [15:0] rm, rq;
    logic signed [31:0] sm, sq;
    logic [31:0] e;

    vecs[0] = '{1'b0, 8'd15,  8'd15,  16'h00E1};
    vecs[1] = '{1'b1, 8'hFF,  8'd6,   16'hFFFA};
    vecs[2] = '{1'b1, 8'hFD,  8'd6,   16'hFFEE};
    vecs[3] = '{1'b1, 8'h80,  8'h80,  16'h4000};
    vecs[4] = '{1'b0, 8'hFF,  8'd6,   16'h05FA};
    vecs[5] = '{1'b1, 8'hFF,  8'd6,   16'hFFFA};
    vecs[6] = '{1'b0, 8'hFF,  8'hFF,  16'hFE01};
    vecs[7] = '{1'b1, 8'h7F,  8'h80,  16'hC080};
    vecs[8] = '{1'b0, 8'd0,   8'd200, 16'h0000};
    vecs[9] = '{1'b0, 8'h80,  8'h80,  16'h4000};

    rst = 1'b1; start8 = 1'b0; tc8 = 1'b0; m8 = '0; q8 = '0;
    start16 = 1'b0; tc16 = 1'b0; m16 = '0; q16 = '0;
    @(negedge clk);
    check("reset busy", 64'(busy8), 64'd0);
    check("reset done", 64'(done8), 64'd0);
    check("reset z", 64'(z8), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) mult8($sformatf("vec%0d", i), vecs[i].tc, vecs[i].m, vecs[i].q, vecs[i].z);

    // start re-pulsed mid-run with new operands must be ignored
    start_8(1'b0, 8'd3, 8'd5);
    repeat (3) @(negedge clk);
    start8 = 1'b1; m8 = 8'd7; q8 = 8'd9;
    @(posedge clk);
    #1 start8 = 1'b0;
    wait8(lat, bc, ov);
    check("ignored start z", 64'(z8), 64'h000F);
    check("ignored start latency", 64'(lat), 64'd7);

    // start held high in DONE launches the next multiply immediately
    mult8("b2b first", 1'b0, 8'd10, 8'd20, 16'h00C8);
    start8 = 1'b1; tc8 = 1'b0; m8 = 8'd12; q8 = 8'd13;
    @(posedge clk);
    #1 start8 = 1'b0;
    check("b2b z held", 64'(z8), 64'h00C8);
    wait8(lat, bc, ov);
    check("b2b second z", 64'(z8), 64'h009C);
    check("b2b second latency", 64'(lat), 64'd10);
    check("b2b second busy cycles", 64'(bc), 64'd9);

    // reset in RUN cycle 4 aborts without a done pulse
    start_8(1'b0, 8'd200, 8'd3);
    repeat (4) @(negedge clk);
    check("abort busy before rst", 64'(busy8), 64'd1);
    rst = 1'b1;
    #1;
    check("abort busy", 64'(busy8), 64'd0);
    check("abort done", 64'(done8), 64'd0);
    check("abort z", 64'(z8), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done8 || busy8) seen = 1'b1;
    end
    check("abort no done", 64'(seen), 64'd0);
    mult8("after abort", 1'b0, 8'd0, 8'd1, 16'h0000);

    mult16("w16 max unsigned", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    mult16("w16 min signed", 1'b1, 16'h8000, 16'h8000, 32'h40000000);
    for (int mode = 0; mode < 2; mode++) begin
      for (int n = 0; n < 1000; n++) begin
        rm = 16'($urandom_range(0, 65535));
        rq = 16'($urandom_range(0, 65535));
        if (mode == 0) begin
          e = {16'h0, rm} * {16'h0, rq};
        end else begin
          sm = $signed(rm);
          sq = $signed(rq);
          e = sm * sq;
        end
        mult16($sformatf("w16 tc=%0d m=%0h q=%0h", mode, rm, rq), mode[0], rm, rq, e);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
